// File: rtl/baud_gen.sv
// SPI serial-clock generator: divides PCLK by (SPPR+1)*2^(SPR+1) and emits edge strobes.
// Optional macro BAUD_DIV_REG_EN registers the divisor (one PCLK latency, reset value 2).
module baud_gen #(
    parameter int CNT_W = 12
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             spiswai_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             ss_i,
    input  logic [1:0]       spi_mode_i,
    input  logic [2:0]       sppr_i,
    input  logic [2:0]       spr_i,
    output logic             sclk_o,
    output logic             miso_recieve_sclk_o,
    output logic             miso_recieve_sclk0_o,
    output logic             mosi_send_sclk_o,
    output logic             mosi_send_sclk0_o,
    output logic [CNT_W-1:0] BaudRateDivisor_o
);

    logic [CNT_W-1:0] div_comb;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] half_m1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic [3:0]       strobe_q, strobe_d;
    logic             enable;
    logic             sample_next;

    always_comb begin
        div_comb = (CNT_W'(sppr_i) + CNT_W'(1)) << ({1'b0, spr_i} + 4'd1);
    end

`ifdef BAUD_DIV_REG_EN
    logic [CNT_W-1:0] div_q, div_d;

    assign div_d = div_comb;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            div_q <= CNT_W'(2);
        end else begin
            div_q <= div_d;
        end
    end

    assign div_cur = div_q;
`else
    assign div_cur = div_comb;
`endif

    assign half_m1 = (div_cur >> 1) - CNT_W'(1);

    assign enable = !ss_i && ((spi_mode_i == 2'b00) ||
                              ((spi_mode_i == 2'b01) && !spiswai_i));

    // Strobes are predicted from the next counter value so that, once registered,
    // they are high exactly in the cycle where the counter sits at H-1.
    always_comb begin
        cnt_d       = '0;
        sclk_d      = cpol_i;
        strobe_d    = 4'b0000;
        sample_next = 1'b0;
        if (enable) begin
            if (cnt_q >= half_m1) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                sclk_d = sclk_q;
            end
            if (cnt_d == half_m1) begin
                sample_next = (sclk_d == cpol_i) ^ cpha_i;
                if (sample_next) begin
                    strobe_d = sclk_d ? 4'b0100 : 4'b1000;
                end else begin
                    strobe_d = sclk_d ? 4'b0001 : 4'b0010;
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q    <= '0;
            sclk_q   <= cpol_i;
            strobe_q <= 4'b0000;
        end else begin
            cnt_q    <= cnt_d;
            sclk_q   <= sclk_d;
            strobe_q <= strobe_d;
        end
    end

    assign sclk_o               = sclk_q;
    assign miso_recieve_sclk_o  = strobe_q[3];
    assign miso_recieve_sclk0_o = strobe_q[2];
    assign mosi_send_sclk_o     = strobe_q[1];
    assign mosi_send_sclk0_o    = strobe_q[0];
    assign BaudRateDivisor_o    = div_cur;

endmodule

// File: tb/tb_baud_gen.sv
// Scoreboard bench for baud_gen: a closed-form sclk/strobe model per (cpol, cpha, H).
module tb_baud_gen;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        spiswai_i, cpol_i, cpha_i, ss_i;
    logic [1:0]  spi_mode_i;
    logic [2:0]  sppr_i, spr_i;
    logic        sclk_o;
    logic        miso_recieve_sclk_o, miso_recieve_sclk0_o;
    logic        mosi_send_sclk_o, mosi_send_sclk0_o;
    logic [11:0] BaudRateDivisor_o;
    logic [3:0]  strb_obs;

    typedef struct packed {
        logic       sclk;
        logic [3:0] strb;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Strobe vector order: {miso rise, miso fall, mosi rise, mosi fall}, indexed by {cpol, cpha}
    localparam logic [3:0] RISE_TAB [4] = '{4'b1000, 4'b0010, 4'b0010, 4'b1000};
    localparam logic [3:0] FALL_TAB [4] = '{4'b0001, 4'b0100, 4'b0100, 4'b0001};

    baud_gen #(.CNT_W(12)) dut (
        .PCLK                 (PCLK),
        .PRESET               (PRESET),
        .spiswai_i            (spiswai_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .ss_i                 (ss_i),
        .spi_mode_i           (spi_mode_i),
        .sppr_i               (sppr_i),
        .spr_i                (spr_i),
        .sclk_o               (sclk_o),
        .miso_recieve_sclk_o  (miso_recieve_sclk_o),
        .miso_recieve_sclk0_o (miso_recieve_sclk0_o),
        .mosi_send_sclk_o     (mosi_send_sclk_o),
        .mosi_send_sclk0_o    (mosi_send_sclk0_o),
        .BaudRateDivisor_o    (BaudRateDivisor_o)
    );

    assign strb_obs = {miso_recieve_sclk_o, miso_recieve_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o};

    always #5 PCLK = ~PCLK;

    // Expected state k PCLK edges after enable: sclk toggles every h edges, strobe when k mod h == h-1
    function automatic exp_t model(input int k, input logic cpol, input logic cpha, input int h);
        exp_t e;
        e.sclk = cpol ^ (((k / h) % 2) == 1);
        e.strb = 4'b0000;
        if ((k % h) == (h - 1)) begin
            e.strb = e.sclk ? FALL_TAB[{cpol, cpha}] : RISE_TAB[{cpol, cpha}];
        end
        return e;
    endfunction

    task automatic test_reset;
        #1;
        total++;
        if (sclk_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_sclk: got %b want 0", sclk_o);
        end
        total++;
        if (strb_obs !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_strobes: got %b want 0000", strb_obs);
        end
        total++;
        if (BaudRateDivisor_o !== 12'd2) begin
            bad++;
            $display("[TB] FAIL reset_divisor: got %0d want 2", BaudRateDivisor_o);
        end
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
    endtask

    task automatic test_divisor;
        logic [2:0] pp [7] = '{3'd0, 3'd1, 3'd7, 3'd2, 3'd5, 3'd0, 3'd7};
        logic [2:0] rr [7] = '{3'd0, 3'd0, 3'd7, 3'd3, 3'd1, 3'd7, 3'd0};
        int expdiv;
        ss_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sppr_i = pp[i];
            spr_i  = rr[i];
            expdiv = (int'(pp[i]) + 1) * (1 << (int'(rr[i]) + 1));
            @(posedge PCLK);
            #1;
            total++;
            if (BaudRateDivisor_o !== 12'(expdiv)) begin
                bad++;
                $display("[TB] FAIL divisor sppr=%0d spr=%0d: got %0d want %0d", pp[i], rr[i], BaudRateDivisor_o, expdiv);
            end
        end
    endtask

    task automatic test_mode(input logic cpol, input logic cpha, input logic [2:0] sppr,
                             input logic [2:0] spr, input logic [1:0] mode, input logic wai, input int n);
        int   h;
        int   expdiv;
        exp_t e;
        ss_i       = 1'b1;
        cpol_i     = cpol;
        cpha_i     = cpha;
        sppr_i     = sppr;
        spr_i      = spr;
        spi_mode_i = mode;
        spiswai_i  = wai;
        repeat (2) @(posedge PCLK);
        #1;
        expdiv = (int'(sppr) + 1) * (1 << (int'(spr) + 1));
        total++;
        if (BaudRateDivisor_o !== 12'(expdiv)) begin
            bad++;
            $display("[TB] FAIL mode_divisor: got %0d want %0d", BaudRateDivisor_o, expdiv);
        end
        total++;
        if (sclk_o !== cpol || strb_obs !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL mode_idle: got sclk=%b strb=%b want sclk=%b strb=0000", sclk_o, strb_obs, cpol);
        end
        h    = expdiv / 2;
        ss_i = 1'b0;
        for (int k = 1; k <= n; k++) begin
            sb_q.push_back(model(k, cpol, cpha, h));
            @(posedge PCLK);
            #1;
            e = sb_q.pop_front();
            total++;
            if (sclk_o !== e.sclk || strb_obs !== e.strb) begin
                bad++;
                $display("[TB] FAIL mode cpol=%b cpha=%b div=%0d k=%0d: got sclk=%b strb=%b want sclk=%b strb=%b",
                         cpol, cpha, expdiv, k, sclk_o, strb_obs, e.sclk, e.strb);
            end
        end
        ss_i = 1'b1;
    endtask

    task automatic test_gating;
        exp_t e;
        ss_i = 1'b1; cpol_i = 1'b1; cpha_i = 1'b0; sppr_i = 3'd1; spr_i = 3'd0;
        spi_mode_i = 2'b00; spiswai_i = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        ss_i = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       ss_i = 1'b1;
                1:       spi_mode_i = 2'b10;
                2:       spi_mode_i = 2'b11;
                default: begin spi_mode_i = 2'b01; spiswai_i = 1'b1; end
            endcase
            for (int j = 0; j < 3; j++) begin
                @(posedge PCLK);
                #1;
                total++;
                if (sclk_o !== 1'b1 || strb_obs !== 4'b0000) begin
                    bad++;
                    $display("[TB] FAIL gate%0d cyc%0d: got sclk=%b strb=%b want sclk=1 strb=0000", c, j, sclk_o, strb_obs);
                end
            end
            ss_i = 1'b0; spi_mode_i = 2'b00; spiswai_i = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                sb_q.push_back(model(k, 1'b1, 1'b0, 2));
                @(posedge PCLK);
                #1;
                e = sb_q.pop_front();
                total++;
                if (sclk_o !== e.sclk || strb_obs !== e.strb) begin
                    bad++;
                    $display("[TB] FAIL gate%0d_resume k=%0d: got sclk=%b strb=%b want sclk=%b strb=%b",
                             c, k, sclk_o, strb_obs, e.sclk, e.strb);
                end
            end
        end
        ss_i = 1'b1;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        ss_i = 1'b1; cpol_i = 1'b1; cpha_i = 1'b0; sppr_i = 3'd3; spr_i = 3'd0;
        spi_mode_i = 2'b00; spiswai_i = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        ss_i = 1'b0;
        repeat (7) @(posedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        total++;
        if (sclk_o !== 1'b1 || strb_obs !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_async: got sclk=%b strb=%b want sclk=1 strb=0000", sclk_o, strb_obs);
        end
        @(posedge PCLK);
        #1;
        total++;
        if (sclk_o !== 1'b1 || strb_obs !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_held: got sclk=%b strb=%b want sclk=1 strb=0000", sclk_o, strb_obs);
        end
        PRESET = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            sb_q.push_back(model(k, 1'b1, 1'b0, 4));
            @(posedge PCLK);
            #1;
            e = sb_q.pop_front();
            total++;
            if (sclk_o !== e.sclk || strb_obs !== e.strb) begin
                bad++;
                $display("[TB] FAIL reset_resume k=%0d: got sclk=%b strb=%b want sclk=%b strb=%b",
                         k, sclk_o, strb_obs, e.sclk, e.strb);
            end
        end
        ss_i = 1'b1;
    endtask

    task automatic test_div_change;
        logic       exp_s [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_b [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        exp_t e;
        ss_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; sppr_i = 3'd1; spr_i = 3'd3;
        spi_mode_i = 2'b00; spiswai_i = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        ss_i = 1'b0;
        repeat (10) @(posedge PCLK);
        #1;
        spr_i = 3'd0;
        #1;
        total++;
        if (BaudRateDivisor_o !== 12'd4) begin
            bad++;
            $display("[TB] FAIL divchange_divisor: got %0d want 4", BaudRateDivisor_o);
        end
        for (int i = 0; i < 5; i++) begin
            e.sclk = exp_s[i];
            e.strb = exp_b[i];
            sb_q.push_back(e);
            @(posedge PCLK);
            #1;
            e = sb_q.pop_front();
            total++;
            if (sclk_o !== e.sclk || strb_obs !== e.strb) begin
                bad++;
                $display("[TB] FAIL divchange edge%0d: got sclk=%b strb=%b want sclk=%b strb=%b",
                         i + 11, sclk_o, strb_obs, e.sclk, e.strb);
            end
        end
        ss_i = 1'b1;
    endtask

    initial begin
        spiswai_i  = 1'b0;
        cpol_i     = 1'b0;
        cpha_i     = 1'b0;
        ss_i       = 1'b1;
        spi_mode_i = 2'b00;
        sppr_i     = 3'd0;
        spr_i      = 3'd0;
        #1;
        PRESET = 1'b1;
        test_reset;
        test_divisor;
        test_mode(1'b0, 1'b0, 3'd1, 3'd0, 2'b00, 1'b0, 16);
        test_mode(1'b1, 1'b1, 3'd3, 3'd0, 2'b00, 1'b0, 32);
        test_mode(1'b0, 1'b1, 3'd2, 3'd0, 2'b00, 1'b0, 24);
        test_mode(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 8);
        test_mode(1'b0, 1'b0, 3'd7, 3'd7, 2'b00, 1'b0, 2100);
        test_gating;
        test_mode(1'b0, 1'b1, 3'd1, 3'd1, 2'b01, 1'b0, 24);
        test_reset_mid;
        test_div_change;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
